// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, mask width,
// and a helper that sizes the round-robin pointer.
package mem_arb_pkg;

    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Pointer/index width; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first asserted
// request at or after i_ptr (wrapping), as a one-hot grant plus its index.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    // Scan the N candidates starting at the pointer; first hit wins.
    always_comb begin
        int w_cand;
        logic [PW-1:0] w_c;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        w_c     = '0;
        for (int off = 0; off < N; off++) begin
            w_cand = int'(i_ptr) + off;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_c = PW'(w_cand);
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = w_c;
                o_grant[w_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one blocking memory port between NUM_REQ requesters.
// A request is accepted in IDLE, issued to memory in ISSUE with a valid/ready
// handshake, and its response is awaited in WAIT; the grant is held for the
// whole access. Responses return one-hot the cycle after i_mem_rvalid.
// Optional macro MEM_ARB_PRIO0_EN: requester 0 wins whenever valid in IDLE,
// without moving the round-robin pointer.
//
// Handshakes: a request transfers on a cycle where i_req_valid[k] and
// o_req_ready[k] are both 1 (o_req_ready only in IDLE); a memory request
// transfers on a cycle where o_mem_valid and i_mem_ready are both 1; the
// response is a single-cycle i_mem_rvalid pulse, sampled only in WAIT.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    localparam int PW     = ptr_width(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*AW-1:0]     i_req_addr,
    input  logic [NUM_REQ-1:0]        i_req_wen,
    input  logic [NUM_REQ*DW-1:0]     i_req_wdata,
    input  logic [NUM_REQ*MASK_W-1:0] i_req_mask,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DW-1:0]             o_rsp_rdata,
    output logic                      o_mem_valid,
    output logic [AW-1:0]             o_mem_addr,
    output logic                      o_mem_ren,
    output logic                      o_mem_wen,
    output logic [DW-1:0]             o_mem_wdata,
    output logic [MASK_W-1:0]         o_mem_mask,
    input  logic                      i_mem_ready,
    input  logic                      i_mem_rvalid,
    input  logic [DW-1:0]             i_mem_rdata,
    output logic [1:0]                o_dbg_state,
    output logic [PW-1:0]             o_dbg_ptr
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_id;
    logic [AW-3:0]       r_addr;
    logic                r_wen;
    logic [DW-1:0]       r_wdata;
    logic [MASK_W-1:0]   r_mask;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DW-1:0]       r_rsp_rdata;

    logic [NUM_REQ-1:0]  w_rr_grant;
    logic [PW-1:0]       w_rr_idx;
    logic                w_rr_any;
    logic [NUM_REQ-1:0]  w_win_grant;
    logic [PW-1:0]       w_win_idx;
    logic                w_win_any;
    logic                w_ptr_upd;
    logic [PW-1:0]       w_ptr_nxt;
    logic                w_accept;
    logic                w_mem_valid;
    logic [NUM_REQ-1:0]  w_id_onehot;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

`ifdef MEM_ARB_PRIO0_EN
    // Requester 0 overrides round-robin and leaves the pointer untouched.
    always_comb begin
        w_win_grant = w_rr_grant;
        w_win_idx   = w_rr_idx;
        w_win_any   = w_rr_any;
        w_ptr_upd   = 1'b1;
        if (i_req_valid[0]) begin
            w_win_grant = NUM_REQ'(1);
            w_win_idx   = '0;
            w_win_any   = 1'b1;
            w_ptr_upd   = 1'b0;
        end
    end
`else
    // Pure round-robin over all requesters.
    always_comb begin
        w_win_grant = w_rr_grant;
        w_win_idx   = w_rr_idx;
        w_win_any   = w_rr_any;
        w_ptr_upd   = 1'b1;
    end
`endif

    // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
    always_comb begin
        w_ptr_nxt = '0;
        if (w_win_idx != PW'(NUM_REQ - 1)) begin
            w_ptr_nxt = w_win_idx + PW'(1);
        end
    end

    assign w_accept    = (r_state == ST_IDLE) && w_win_any && !i_rst;
    assign w_mem_valid = (r_state == ST_ISSUE);
    assign w_id_onehot = NUM_REQ'(1) << r_id;

    // Next-state logic: accept -> issue -> wait for response -> idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (i_mem_ready)  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (i_mem_rvalid) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner's request fields and advance the pointer on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else if (w_accept) begin
            r_id    <= w_win_idx;
            r_addr  <= i_req_addr[w_win_idx*AW + 2 +: AW-2];
            r_wen   <= i_req_wen[w_win_idx];
            r_wdata <= i_req_wdata[w_win_idx*DW +: DW];
            r_mask  <= i_req_mask[w_win_idx*MASK_W +: MASK_W];
            if (w_ptr_upd) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Capture the memory response and present it one-hot for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if ((r_state == ST_WAIT) && i_mem_rvalid) begin
                r_rsp_valid <= w_id_onehot;
                r_rsp_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_req_ready = w_accept ? w_win_grant : '0;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_valid = w_mem_valid;
    assign o_mem_addr  = {r_addr, 2'b00};
    assign o_mem_ren   = w_mem_valid & ~r_wen;
    assign o_mem_wen   = w_mem_valid & r_wen;
    assign o_mem_wdata = r_wdata;
    assign o_mem_mask  = r_mask;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with three requesters. Inputs change
// 1ns after the rising edge; outputs are checked on the falling edge.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_wen;
    logic [31:0]   a [N];
    logic [31:0]   wd [N];
    logic [3:0]    m [N];
    logic          mem_ready;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    logic [N-1:0]    o_req_ready;
    logic [N-1:0]    o_rsp_valid;
    logic [DW-1:0]   o_rsp_rdata;
    logic            o_mem_valid;
    logic [AW-1:0]   o_mem_addr;
    logic            o_mem_ren;
    logic            o_mem_wen;
    logic [DW-1:0]   o_mem_wdata;
    logic [3:0]      o_mem_mask;
    logic [1:0]      o_dbg_state;
    logic [1:0]      o_dbg_ptr;

    logic [N*AW-1:0] w_addr_bus;
    logic [N*DW-1:0] w_wdata_bus;
    logic [N*4-1:0]  w_mask_bus;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    assign w_addr_bus  = {a[2], a[1], a[0]};
    assign w_wdata_bus = {wd[2], wd[1], wd[0]};
    assign w_mask_bus  = {m[2], m[1], m[0]};

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_addr   (w_addr_bus),
        .i_req_wen    (req_wen),
        .i_req_wdata  (w_wdata_bus),
        .i_req_mask   (w_mask_bus),
        .o_req_ready  (o_req_ready),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_mem_valid  (o_mem_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_ready  (mem_ready),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_dbg_state  (o_dbg_state),
        .o_dbg_ptr    (o_dbg_ptr)
    );

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        req_wen    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int k = 0; k < N; k++) begin
            a[k]  = '0;
            wd[k] = '0;
            m[k]  = '0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if ({o_req_ready, o_rsp_valid} !== 6'b0) begin n_errors++; $display("FAIL reset_ready_rsp: got %b want 000000", {o_req_ready, o_rsp_valid}); end
        n_checks++; if ({o_mem_valid, o_mem_ren, o_mem_wen} !== 3'b000) begin n_errors++; $display("FAIL reset_mem_ctl: got %b want 000", {o_mem_valid, o_mem_ren, o_mem_wen}); end
        n_checks++; if (o_mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
        n_checks++; if ({o_mem_wdata, o_mem_mask} !== 36'h0) begin n_errors++; $display("FAIL reset_mem_data: got %h want 0", {o_mem_wdata, o_mem_mask}); end
        n_checks++; if (o_rsp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h want 0", o_rsp_rdata); end
        n_checks++; if ({o_dbg_state, o_dbg_ptr} !== 4'b0) begin n_errors++; $display("FAIL reset_state_ptr: got %b want 0000", {o_dbg_state, o_dbg_ptr}); end
        next_cycle();
    endtask

    task automatic test_single_load();
        req_valid = 3'b001; req_wen = 3'b000; a[0] = 32'h0000_1006; m[0] = 4'b1100;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b001) begin n_errors++; $display("FAIL load_ready: got %b want 001", o_req_ready); end
        next_cycle();
        req_valid = 3'b000; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_mem_valid, o_mem_ren, o_mem_wen} !== 3'b110) begin n_errors++; $display("FAIL load_mem_ctl: got %b want 110", {o_mem_valid, o_mem_ren, o_mem_wen}); end
        n_checks++; if (o_mem_addr !== 32'h0000_1004) begin n_errors++; $display("FAIL load_mem_addr: got %h want 00001004", o_mem_addr); end
        n_checks++; if (o_mem_mask !== 4'b1100) begin n_errors++; $display("FAIL load_mem_mask: got %b want 1100", o_mem_mask); end
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if ({o_dbg_state, o_mem_valid, o_rsp_valid} !== 6'b10_0_000) begin n_errors++; $display("FAIL load_wait: got %b want 100000", {o_dbg_state, o_mem_valid, o_rsp_valid}); end
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++; if (o_rsp_valid !== 3'b001) begin n_errors++; $display("FAIL load_rsp_valid: got %b want 001", o_rsp_valid); end
        n_checks++; if (o_rsp_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL load_rsp_rdata: got %h want deadbeef", o_rsp_rdata); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (o_rsp_valid !== 3'b000) begin n_errors++; $display("FAIL load_rsp_pulse: got %b want 000", o_rsp_valid); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        logic [1:0] prev_id;
        logic [2:0] exp_oh;
        apply_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        for (int k = 0; k < N; k++) a[k] = 32'h100 * (k + 1) + 1;
        req_valid = 3'b111; mem_ready = 1'b1; mem_rvalid = 1'b1;
        prev_id = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            exp_id = exp_q.pop_front();
            exp_oh = 3'b001 << exp_id;
            n_checks++; if (o_req_ready !== exp_oh) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b want %b", j, o_req_ready, exp_oh); end
            if (j > 0) begin
                exp_oh = 3'b001 << prev_id;
                n_checks++; if (o_rsp_valid !== exp_oh) begin n_errors++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", j, o_rsp_valid, exp_oh); end
                n_checks++; if (o_rsp_rdata !== 32'h5000_0000 + 32'(j - 1)) begin n_errors++; $display("FAIL rr_rsp_rdata[%0d]: got %h want %h", j, o_rsp_rdata, 32'h5000_0000 + 32'(j - 1)); end
            end
            prev_id = exp_id;
            next_cycle();
            @(negedge clk);
            n_checks++; if ({o_mem_valid, o_mem_addr} !== {1'b1, 32'h100 * (32'(exp_id) + 1)}) begin n_errors++; $display("FAIL rr_mem_addr[%0d]: got %b/%h want 1/%h", j, o_mem_valid, o_mem_addr, 32'h100 * (32'(exp_id) + 1)); end
            next_cycle();
            mem_rdata = 32'h5000_0000 + 32'(j);
            next_cycle();
        end
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if ({o_rsp_valid, o_req_ready} !== 6'b100_000) begin n_errors++; $display("FAIL rr_last_rsp: got %b want 100000", {o_rsp_valid, o_req_ready}); end
        n_checks++; if (o_rsp_rdata !== 32'h5000_0005) begin n_errors++; $display("FAIL rr_last_rdata: got %h want 50000005", o_rsp_rdata); end
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        next_cycle();
    endtask

    task automatic test_store_stall();
        // pointer is 0 after the last grant to requester 2
        req_valid = 3'b100; req_wen = 3'b100;
        a[2] = 32'h0000_2003; wd[2] = 32'h0000_AB00; m[2] = 4'b0010;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b100) begin n_errors++; $display("FAIL st_ready: got %b want 100", o_req_ready); end
        next_cycle();
        req_valid = 3'b001; a[0] = 32'h0000_3000; m[0] = 4'b1111; mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if ({o_mem_valid, o_mem_ren, o_mem_wen, o_req_ready} !== 6'b101_000) begin n_errors++; $display("FAIL st_hold_ctl[%0d]: got %b want 101000", c, {o_mem_valid, o_mem_ren, o_mem_wen, o_req_ready}); end
            n_checks++; if ({o_mem_addr, o_mem_wdata, o_mem_mask} !== {32'h0000_2000, 32'h0000_AB00, 4'b0010}) begin n_errors++; $display("FAIL st_hold_fields[%0d]: got %h/%h/%b want 00002000/0000ab00/0010", c, o_mem_addr, o_mem_wdata, o_mem_mask); end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_mem_valid, o_req_ready} !== 4'b1_000) begin n_errors++; $display("FAIL st_issue: got %b want 1000", {o_mem_valid, o_req_ready}); end
        next_cycle();
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({o_dbg_state, o_mem_valid, o_req_ready} !== 6'b10_0_000) begin n_errors++; $display("FAIL st_wait[%0d]: got %b want 100000", c, {o_dbg_state, o_mem_valid, o_req_ready}); end
            next_cycle();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({o_rsp_valid, o_req_ready} !== 6'b100_001) begin n_errors++; $display("FAIL st_rsp_and_next: got %b want 100001", {o_rsp_valid, o_req_ready}); end
        n_checks++; if (o_rsp_rdata !== 32'h1111_2222) begin n_errors++; $display("FAIL st_rsp_rdata: got %h want 11112222", o_rsp_rdata); end
        next_cycle();
        req_valid = 3'b000; req_wen = 3'b000; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_mem_valid, o_mem_ren, o_mem_addr} !== {2'b11, 32'h0000_3000}) begin n_errors++; $display("FAIL st_follow_issue: got %b%b/%h want 11/00003000", o_mem_valid, o_mem_ren, o_mem_addr); end
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({o_rsp_valid, o_rsp_rdata} !== {3'b001, 32'h3333_4444}) begin n_errors++; $display("FAIL st_follow_rsp: got %b/%h want 001/33334444", o_rsp_valid, o_rsp_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        // pointer is 1 after the last grant to requester 0
        req_valid = 3'b010; a[1] = 32'h0000_0040; m[1] = 4'b1111;
        @(negedge clk);
        n_checks++; if ({o_req_ready, o_dbg_ptr} !== 5'b010_01) begin n_errors++; $display("FAIL rw_accept: got %b want 01001", {o_req_ready, o_dbg_ptr}); end
        next_cycle();
        req_valid = 3'b000; mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_dbg_state, o_dbg_ptr} !== 4'b10_10) begin n_errors++; $display("FAIL rw_in_wait: got %b want 1010", {o_dbg_state, o_dbg_ptr}); end
        next_cycle();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++; if ({o_dbg_state, o_dbg_ptr, o_req_ready, o_rsp_valid} !== 10'b0) begin n_errors++; $display("FAIL rw_after_rst: got %b want 0", {o_dbg_state, o_dbg_ptr, o_req_ready, o_rsp_valid}); end
        n_checks++; if ({o_mem_valid, o_mem_ren, o_mem_wen, o_mem_addr, o_mem_mask, o_rsp_rdata} !== 71'b0) begin n_errors++; $display("FAIL rw_outputs_zero: got %b%b%b/%h/%b/%h want 0", o_mem_valid, o_mem_ren, o_mem_wen, o_mem_addr, o_mem_mask, o_rsp_rdata); end
        next_cycle();
        @(negedge clk);
        n_checks++; if ({o_rsp_valid, o_dbg_state} !== 5'b0) begin n_errors++; $display("FAIL rw_late_rvalid: got %b want 00000", {o_rsp_valid, o_dbg_state}); end
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_prio();
        logic [1:0] exp_id;
        logic [2:0] exp_oh;
        apply_reset();
`ifdef MEM_ARB_PRIO0_EN
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        a[0] = 32'h0000_0010; a[1] = 32'h0000_0020;
        req_valid = 3'b011; mem_ready = 1'b1; mem_rvalid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            exp_id = exp_q.pop_front();
            exp_oh = 3'b001 << exp_id;
            n_checks++; if (o_req_ready !== exp_oh) begin n_errors++; $display("FAIL prio_grant[%0d]: got %b want %b", j, o_req_ready, exp_oh); end
            next_cycle();
            @(negedge clk);
            n_checks++; if (o_mem_addr !== 32'h10 * (32'(exp_id) + 1)) begin n_errors++; $display("FAIL prio_addr[%0d]: got %h want %h", j, o_mem_addr, 32'h10 * (32'(exp_id) + 1)); end
            next_cycle();
            next_cycle();
        end
        req_valid = 3'b000; mem_ready = 1'b0; mem_rvalid = 1'b0;
        next_cycle();
    endtask

    task automatic test_spurious();
        req_valid = 3'b000; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({o_dbg_state, o_mem_valid, o_rsp_valid} !== 6'b0) begin n_errors++; $display("FAIL sp_idle[%0d]: got %b want 000000", c, {o_dbg_state, o_mem_valid, o_rsp_valid}); end
            next_cycle();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        req_valid = 3'b100; req_wen = 3'b000; a[2] = 32'h0000_0080; m[2] = 4'b0001;
        @(negedge clk);
        n_checks++; if (o_req_ready !== 3'b100) begin n_errors++; $display("FAIL sp_accept: got %b want 100", o_req_ready); end
        next_cycle();
        req_valid = 3'b000; mem_rvalid = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_dbg_state, o_mem_valid} !== 3'b01_1) begin n_errors++; $display("FAIL sp_issue: got %b want 011", {o_dbg_state, o_mem_valid}); end
        next_cycle();
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({o_dbg_state, o_rsp_valid} !== 5'b01_000) begin n_errors++; $display("FAIL sp_issue_hold: got %b want 01000", {o_dbg_state, o_rsp_valid}); end
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({o_dbg_state, o_mem_valid, o_rsp_valid} !== 6'b10_0_000) begin n_errors++; $display("FAIL sp_wait[%0d]: got %b want 100000", c, {o_dbg_state, o_mem_valid, o_rsp_valid}); end
            next_cycle();
        end
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({o_rsp_valid, o_rsp_rdata, o_dbg_state} !== {3'b100, 32'h0F0F_0F0F, 2'b00}) begin n_errors++; $display("FAIL sp_rsp: got %b/%h/%b want 100/0f0f0f0f/00", o_rsp_valid, o_rsp_rdata, o_dbg_state); end
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_load();
        test_round_robin();
        test_store_stall();
        test_reset_in_wait();
        test_prio();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
